// File: rtl/pi_disp_pkg.sv
// Shared parameters, FSM state encoding and digit helpers for the pi digit server.
// Geometry matches the result RAM of the multi-precision calculator.
package pi_disp_pkg;
    localparam int L        = 47;
    localparam int N        = 10;
    localparam int ADR_BITS = 6;
    localparam int RAMDELAY = 2;
    localparam int IDX_BITS = 9;

    localparam int RD_CNT_BITS = (RAMDELAY > 1) ? $clog2(RAMDELAY) : 1;

    localparam logic [3:0]          DIGIT_INVALID = 4'hF;
    localparam logic [IDX_BITS-1:0] IDX_LIMIT     = IDX_BITS'(3 * L);
    localparam logic [IDX_BITS-1:0] TOP_LIMB      = IDX_BITS'(L - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        CAPTURE,
        CONV_H,
        CONV_T,
        RESP
    } state_t;

    // pos 0 is the hundreds digit of a limb, 2 the ones digit.
    function automatic logic [3:0] pick_digit(input logic [1:0] pos,
                                              input logic [3:0] h,
                                              input logic [3:0] t,
                                              input logic [3:0] o);
        case (pos)
            2'd0:    return h;
            2'd1:    return t;
            2'd2:    return o;
            default: return DIGIT_INVALID;
        endcase
    endfunction
endpackage

// File: rtl/pi_digit_server_limb_to_bcd.sv
// Sequential base-1000 to three-digit BCD converter: repeated subtraction of
// 100 then 10, one step per cycle, remainder is the ones digit.
module limb_to_bcd
    import pi_disp_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] value,
    output logic         tens_next,
    output logic         done,
    output logic         bad,
    output logic [3:0]   h,
    output logic [3:0]   t,
    output logic [3:0]   o
);
    typedef enum logic [1:0] {PH_IDLE, PH_H, PH_T} phase_t;

    phase_t       phase_reg;
    logic [N-1:0] w_reg;

    assign bad       = (value >= N'(1000));
    assign tens_next = (phase_reg == PH_H) && (w_reg < N'(100));
    assign done      = (phase_reg == PH_T) && (w_reg < N'(10));
    assign o         = w_reg[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= PH_IDLE;
            w_reg     <= '0;
            h         <= 4'd0;
            t         <= 4'd0;
        end else if (abort) begin
            phase_reg <= PH_IDLE;
        end else if (start) begin
            w_reg     <= value;
            h         <= 4'd0;
            t         <= 4'd0;
            phase_reg <= bad ? PH_IDLE : PH_H;
        end else begin
            case (phase_reg)
                PH_H: begin
                    if (w_reg >= N'(100)) begin
                        w_reg <= w_reg - N'(100);
                        h     <= h + 4'd1;
                    end else begin
                        phase_reg <= PH_T;
                    end
                end
                PH_T: begin
                    if (w_reg >= N'(10)) begin
                        w_reg <= w_reg - N'(10);
                        t     <= t + 4'd1;
                    end else begin
                        phase_reg <= PH_IDLE;
                    end
                end
                default: phase_reg <= PH_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/pi_digit_server.sv
// Serves single decimal digits of the finished result to the text renderer,
// fetching one limb at a time and keeping the last converted limb cached.
module pi_digit_server
    import pi_disp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                calc_done,
    output logic [ADR_BITS-1:0] ram_rdadd,
    input  logic [N-1:0]        ram_q,
    input  logic                req,
    input  logic [IDX_BITS-1:0] req_idx,
    output logic                ack,
    output logic [3:0]          digit,
    output logic                err,
    output logic                busy
);
    state_t                 state_reg;
    logic [RD_CNT_BITS-1:0] rd_cnt_reg;
    logic [1:0]             pos_reg;
    logic [ADR_BITS-1:0]    limb_reg;

    logic                   cache_valid_reg;
    logic                   cache_bad_reg;
    logic [ADR_BITS-1:0]    cache_tag_reg;
    logic [3:0]             cache_h_reg;
    logic [3:0]             cache_t_reg;
    logic [3:0]             cache_o_reg;

    logic [ADR_BITS-1:0]    req_limb;
    logic [1:0]             req_pos;
    logic                   out_of_range;
    logic                   cache_hit;

    logic                   conv_tens_next;
    logic                   conv_done;
    logic                   conv_bad;
    logic [3:0]             conv_h;
    logic [3:0]             conv_t;
    logic [3:0]             conv_o;

    // Limb L-1 carries the integer part, so digit index 0 maps to the top limb.
    assign req_limb     = ADR_BITS'(TOP_LIMB - req_idx / IDX_BITS'(3));
    assign req_pos      = 2'(req_idx % IDX_BITS'(3));
    assign out_of_range = (req_idx >= IDX_LIMIT);
    assign cache_hit    = cache_valid_reg && (cache_tag_reg == req_limb);

    limb_to_bcd u_conv (
        .clk       (clk),
        .rst       (rst),
        .start     (state_reg == CAPTURE),
        .abort     (!calc_done),
        .value     (ram_q),
        .tens_next (conv_tens_next),
        .done      (conv_done),
        .bad       (conv_bad),
        .h         (conv_h),
        .t         (conv_t),
        .o         (conv_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            rd_cnt_reg      <= '0;
            pos_reg         <= 2'd0;
            limb_reg        <= '0;
            cache_valid_reg <= 1'b0;
            cache_bad_reg   <= 1'b0;
            cache_tag_reg   <= '0;
            cache_h_reg     <= 4'd0;
            cache_t_reg     <= 4'd0;
            cache_o_reg     <= 4'd0;
            ram_rdadd       <= '0;
            ack             <= 1'b0;
            digit           <= 4'd0;
            err             <= 1'b0;
            busy            <= 1'b0;
        end else begin
            ack <= 1'b0;
            // The RAM may be rewritten once the calculator leaves its end state.
            if (!calc_done)
                cache_valid_reg <= 1'b0;

            if (!calc_done && state_reg != IDLE) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (req && calc_done) begin
                            pos_reg  <= req_pos;
                            limb_reg <= req_limb;
                            busy     <= 1'b1;
                            if (out_of_range) begin
                                state_reg <= RESP;
                                ack       <= 1'b1;
                                digit     <= DIGIT_INVALID;
                                err       <= 1'b1;
                            end else if (cache_hit) begin
                                state_reg <= RESP;
                                ack       <= 1'b1;
                                digit     <= cache_bad_reg ? DIGIT_INVALID :
                                             pick_digit(req_pos, cache_h_reg, cache_t_reg, cache_o_reg);
                                err       <= cache_bad_reg;
                            end else begin
                                ram_rdadd  <= req_limb;
                                rd_cnt_reg <= '0;
                                state_reg  <= RD_WAIT;
                            end
                        end
                    end
                    RD_WAIT: begin
                        if (rd_cnt_reg == RD_CNT_BITS'(RAMDELAY - 1))
                            state_reg <= CAPTURE;
                        else
                            rd_cnt_reg <= rd_cnt_reg + 1'b1;
                    end
                    CAPTURE: begin
                        if (conv_bad) begin
                            cache_valid_reg <= 1'b1;
                            cache_bad_reg   <= 1'b1;
                            cache_tag_reg   <= limb_reg;
                            state_reg       <= RESP;
                            ack             <= 1'b1;
                            digit           <= DIGIT_INVALID;
                            err             <= 1'b1;
                        end else begin
                            state_reg <= CONV_H;
                        end
                    end
                    CONV_H: begin
                        if (conv_tens_next)
                            state_reg <= CONV_T;
                    end
                    CONV_T: begin
                        if (conv_done) begin
                            cache_valid_reg <= 1'b1;
                            cache_bad_reg   <= 1'b0;
                            cache_tag_reg   <= limb_reg;
                            cache_h_reg     <= conv_h;
                            cache_t_reg     <= conv_t;
                            cache_o_reg     <= conv_o;
                            state_reg       <= RESP;
                            ack             <= 1'b1;
                            digit           <= pick_digit(pos_reg, conv_h, conv_t, conv_o);
                            err             <= 1'b0;
                        end
                    end
                    RESP: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pi_digit_server.sv
// Scoreboard bench for pi_digit_server: the stimulus pushes expected digit, err
// and ack cycle; a negedge monitor pops and compares on every ack.
module tb_pi_digit_server;
    import pi_disp_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                calc_done = 1'b1;
    logic [ADR_BITS-1:0] ram_rdadd;
    logic [N-1:0]        ram_q;
    logic                req = 1'b0;
    logic [IDX_BITS-1:0] req_idx = '0;
    logic                ack;
    logic [3:0]          digit;
    logic                err;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         idx;
        logic [3:0] digit;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    logic [N-1:0] mem [2**ADR_BITS];
    logic [N-1:0] ram_pipe [RAMDELAY];

    pi_digit_server dut (
        .clk       (clk),
        .rst       (rst),
        .calc_done (calc_done),
        .ram_rdadd (ram_rdadd),
        .ram_q     (ram_q),
        .req       (req),
        .req_idx   (req_idx),
        .ack       (ack),
        .digit     (digit),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Result RAM with RAMDELAY registered read stages.
    always @(posedge clk) begin
        ram_pipe[0] <= mem[ram_rdadd];
        for (int i = 1; i < RAMDELAY; i++)
            ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_q = ram_pipe[RAMDELAY-1];

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && ack) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack digit=%h err=%b cyc=%0d required no ack", digit, err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (digit !== e.digit || err !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL ack_idx%0d got digit=%h err=%b cyc=%0d required digit=%h err=%b cyc=%0d",
                             e.idx, digit, err, cyc, e.digit, e.err, e.cyc);
                end else begin
                    $display("ack idx=%0d digit=%h err=%b cyc=%0d", e.idx, digit, err, cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp_v);
        end
    endtask

    task automatic push_exp(input int idx, input logic [3:0] d, input logic e, input int lat);
        exp_t x;
        x.idx   = idx;
        x.digit = d;
        x.err   = e;
        x.cyc   = cyc + lat;
        sb.push_back(x);
    endtask

    task automatic wait_ack(input int idx);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 40);
        if (!ack) begin
            checks++;
            errors++;
            $display("FAIL timeout_idx%0d got no ack required ack within 40 cycles", idx);
        end
        req = 1'b0;
    endtask

    task automatic do_req(input int idx, input logic [3:0] d, input logic e, input int lat);
        @(negedge clk);
        req     = 1'b1;
        req_idx = IDX_BITS'(idx);
        push_exp(idx, d, e, lat);
        wait_ack(idx);
    endtask

    initial begin
        int busy_seen;
        for (int i = 0; i < 2**ADR_BITS; i++) mem[i] = '0;
        mem[46] = 10'd3;
        mem[45] = 10'd141;
        mem[44] = 10'd592;
        mem[43] = 10'd999;
        mem[42] = 10'd1000;
        mem[0]  = 10'd57;

        repeat (3) @(negedge clk);
        check("reset_ack", int'(ack), 0);
        check("reset_digit", int'(digit), 0);
        check("reset_err", int'(err), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_rdadd", int'(ram_rdadd), 0);
        rst = 1'b0;

        // Integer part 3: miss then two hits.
        do_req(0, 4'd0, 1'b0, 6);
        do_req(1, 4'd0, 1'b0, 1);
        do_req(2, 4'd3, 1'b0, 1);
        // First fraction group 141.
        do_req(3, 4'd1, 1'b0, 11);
        do_req(5, 4'd1, 1'b0, 1);
        do_req(4, 4'd4, 1'b0, 1);
        // Worst-case limb 999, then an invalid limb 1000.
        do_req(9, 4'd9, 1'b0, 24);
        do_req(10, 4'd9, 1'b0, 1);
        do_req(11, 4'd9, 1'b0, 1);
        do_req(12, 4'hF, 1'b1, 4);
        do_req(13, 4'hF, 1'b1, 1);
        // Out of range must not move the RAM address.
        do_req(141, 4'hF, 1'b1, 1);
        check("oor_rdadd_held", int'(ram_rdadd), 42);
        do_req(140, 4'd7, 1'b0, 11);

        // Requests wait while calc_done is low.
        @(negedge clk);
        calc_done = 1'b0;
        req       = 1'b1;
        req_idx   = IDX_BITS'(6);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("wait_busy_low", busy_seen, 0);
        calc_done = 1'b1;
        push_exp(6, 4'd5, 1'b0, 20);
        wait_ack(6);

        // Abort during CONV_H, then limb 44 must miss again.
        @(negedge clk);
        req     = 1'b1;
        req_idx = IDX_BITS'(9);
        repeat (5) @(negedge clk);
        calc_done = 1'b0;
        req       = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        calc_done = 1'b1;
        do_req(6, 4'd5, 1'b0, 20);

        // Reset during RD_WAIT.
        @(negedge clk);
        req     = 1'b1;
        req_idx = IDX_BITS'(15);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        #1;
        check("midrst_ack", int'(ack), 0);
        check("midrst_digit", int'(digit), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rdadd", int'(ram_rdadd), 0);
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 4'd0, 1'b0, 6);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
